// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W_DEF       = 4;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned MEM_TIMEOUT_DEF = 255;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-controller signal bundle: hazard inputs in, freeze/flush and counters out.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_use_src1;
    logic             id_use_src2;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clear;
    logic             pc_freeze;
    logic             if_freeze;
    logic             if_flush;
    logic             id_flush;
    logic             pipe_freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] hazard_cnt;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] memwait_cnt;

    modport master (
        output id_src1, id_src2, id_use_src1, id_use_src2,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
               branch_taken, mem_req, mem_ready, cnt_clear,
        input  pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze,
               mem_timeout, hazard_cnt, branch_cnt, memwait_cnt
    );

    modport slave (
        input  id_src1, id_src2, id_use_src1, id_use_src2,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
               branch_taken, mem_req, mem_ready, cnt_clear,
        output pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze,
               mem_timeout, hazard_cnt, branch_cnt, memwait_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with memory-wait tracking.
// Build option HAZARD_FWD_EN: forwarding present, only load-use dependencies stall.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = REG_W_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    logic mem_stall;
    logic data_haz;
    logic pc_freeze_c, if_freeze_c, if_flush_c, id_flush_c, pipe_freeze_c;
    logic hazard_inc, branch_inc, memwait_inc;
    logic [CNT_W-1:0] hazard_cnt, branch_cnt, memwait_cnt;

    function automatic logic raw_hit(input logic [REG_W-1:0] d, input logic en);
        return en & (((d == bus.id_src1) & bus.id_use_src1) |
                     ((d == bus.id_src2) & bus.id_use_src2));
    endfunction

    assign mem_stall = bus.mem_req & ~bus.mem_ready;

`ifdef HAZARD_FWD_EN
    logic unused_mem_stage;
    assign unused_mem_stage = ^{bus.mem_dest, bus.mem_wb_en};
    assign data_haz = raw_hit(bus.exe_dest, bus.exe_wb_en & bus.exe_mem_read);
`else
    logic unused_exe_load;
    assign unused_exe_load = bus.exe_mem_read;
    assign data_haz = raw_hit(bus.exe_dest, bus.exe_wb_en) |
                      raw_hit(bus.mem_dest, bus.mem_wb_en);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Wait counter restarts on entry and saturates at the timeout threshold.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
                    if ((MEM_TIMEOUT != 0) && (wait_d == WAIT_MAX)) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Priority: memory stall, then taken branch, then data hazard.
    always_comb begin
        pc_freeze_c   = 1'b0;
        if_freeze_c   = 1'b0;
        if_flush_c    = 1'b0;
        id_flush_c    = 1'b0;
        pipe_freeze_c = 1'b0;
        hazard_inc    = 1'b0;
        branch_inc    = 1'b0;
        memwait_inc   = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                pc_freeze_c   = 1'b1;
                if_freeze_c   = 1'b1;
                pipe_freeze_c = 1'b1;
                memwait_inc   = 1'b1;
            end else if (bus.branch_taken) begin
                if_flush_c = 1'b1;
                id_flush_c = 1'b1;
                branch_inc = 1'b1;
            end else if (data_haz) begin
                pc_freeze_c = 1'b1;
                if_freeze_c = 1'b1;
                id_flush_c  = 1'b1;
                hazard_inc  = 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
        .clk(clk), .rst(rst), .clr(bus.cnt_clear), .inc(hazard_inc), .q(hazard_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk(clk), .rst(rst), .clr(bus.cnt_clear), .inc(branch_inc), .q(branch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .clk(clk), .rst(rst), .clr(bus.cnt_clear), .inc(memwait_inc), .q(memwait_cnt)
    );

    assign bus.pc_freeze   = pc_freeze_c;
    assign bus.if_freeze   = if_freeze_c;
    assign bus.if_flush    = if_flush_c;
    assign bus.id_flush    = id_flush_c;
    assign bus.pipe_freeze = pipe_freeze_c;
    assign bus.mem_timeout = timeout_q;
    assign bus.hazard_cnt  = hazard_cnt;
    assign bus.branch_cnt  = branch_cnt;
    assign bus.memwait_cnt = memwait_cnt;

endmodule
